// File: rtl/motor_period_meas_if.sv
// Period-sample bus from motor_period_meas to the downstream moving-average filter.
interface motor_period_meas_if #(
    parameter int unsigned WIDTH = 16
);
    logic             period_valid;
    logic [WIDTH-1:0] period;
    logic             stall;

    modport master (output period_valid, output period, output stall);
    modport slave  (input  period_valid, input  period, input  stall);
endinterface

// File: rtl/motor_period_meas.sv
// Measures tick count between debounced rising edges of the speed sensor and
// flags a stalled motor when the tick counter saturates before the next edge.
module motor_period_meas #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEB_N    = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pulse_in,
    motor_period_meas_if.master o_meas
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(DEB_N + 1);

    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_MEAS  = 2'd2;
    localparam logic [1:0] S_STALL = 2'd3;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic             r_filt_d;
    logic [DW-1:0]    r_deb_cnt;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_period;
    logic             r_stall;

    logic [1:0]       w_state_nxt;
    logic [PW-1:0]    w_presc_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic             w_stall_nxt;

    logic             w_edge;
    logic             w_tick;
    logic [WIDTH-1:0] w_cnt_inc;

    // Synchronizer and debounce run regardless of enable so the filtered level stays current.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_filt    <= 1'b0;
            r_filt_d  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1  <= pulse_in;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            if (r_sync2 == r_filt) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_filt    <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    assign w_edge    = r_filt & ~r_filt_d;
    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + WIDTH'(w_tick);

    // Next-state and registered-output logic; an edge takes priority over saturation.
    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = w_tick ? '0 : r_presc + PW'(1);
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = 1'b0;
        w_period_nxt = r_period;
        w_stall_nxt  = r_stall;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_cnt_nxt   = '0;
            w_stall_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARM;
                    w_presc_nxt = '0;
                    w_cnt_nxt   = '0;
                end
                S_ARM: begin
                    w_cnt_nxt = '0;
                    if (w_edge) begin
                        w_presc_nxt = '0;
                        w_state_nxt = S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (w_edge) begin
                        w_period_nxt = w_cnt_inc;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = '0;
                        w_presc_nxt  = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_period_nxt = CNT_MAX;
                        w_valid_nxt  = 1'b1;
                        w_stall_nxt  = 1'b1;
                        w_cnt_nxt    = CNT_MAX;
                        w_state_nxt  = S_STALL;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_STALL: begin
                    if (w_edge) begin
                        w_stall_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                        w_presc_nxt = '0;
                        w_state_nxt = S_MEAS;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_stall_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_period <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_period <= w_period_nxt;
            r_stall  <= w_stall_nxt;
        end
    end

    assign o_meas.period_valid = r_valid;
    assign o_meas.period       = r_period;
    assign o_meas.stall        = r_stall;
endmodule

// File: tb/tb_motor_period_meas.sv
// Scoreboard bench for motor_period_meas: three instances cover default, prescaled and 8-bit setups.
module tb_motor_period_meas;
    typedef struct {
        int     p;
        bit     s;
        longint cyc;
    } exp_t;

    typedef struct {
        int     d;
        int     kind;
        int     v;
        longint cyc;
    } lvl_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   en  [3];
    logic   pin [3];
    longint cyc = 0;

    exp_t   exp_q [3][$];
    lvl_t   lvl_q [$];
    int     n_checks = 0;
    int     n_errors = 0;
    bit     done = 1'b0;
    bit     final_done = 1'b0;

    logic        vld      [3];
    logic [15:0] period_w [3];
    logic        stall_w  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    motor_period_meas_if #(.WIDTH(16)) if_a ();
    motor_period_meas_if #(.WIDTH(16)) if_b ();
    motor_period_meas_if #(.WIDTH(8))  if_c ();

    motor_period_meas #(.WIDTH(16), .DEB_N(4), .TICK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .enable(en[0]), .pulse_in(pin[0]), .o_meas(if_a.master));
    motor_period_meas #(.WIDTH(16), .DEB_N(4), .TICK_DIV(8)) u_b (
        .clk(clk), .rst(rst), .enable(en[1]), .pulse_in(pin[1]), .o_meas(if_b.master));
    motor_period_meas #(.WIDTH(8), .DEB_N(4), .TICK_DIV(1)) u_c (
        .clk(clk), .rst(rst), .enable(en[2]), .pulse_in(pin[2]), .o_meas(if_c.master));

    assign vld[0]      = if_a.period_valid;
    assign vld[1]      = if_b.period_valid;
    assign vld[2]      = if_c.period_valid;
    assign period_w[0] = if_a.period;
    assign period_w[1] = if_b.period;
    assign period_w[2] = {8'h00, if_c.period};
    assign stall_w[0]  = if_a.stall;
    assign stall_w[1]  = if_b.stall;
    assign stall_w[2]  = if_c.stall;

    // Monitor: pops expected strobes and timed level checks on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        lvl_t l;
        int   act;
        for (int d = 0; d < 3; d++) begin
            if (vld[d]) begin
                n_checks++;
                if (exp_q[d].size() == 0) begin
                    n_errors++;
                    $display("FAIL strobe dut%0d: unexpected strobe period=%0d stall=%0d cycle=%0d, required none",
                             d, period_w[d], stall_w[d], cyc);
                end else begin
                    e = exp_q[d].pop_front();
                    if (32'(period_w[d]) != e.p || stall_w[d] != e.s || cyc != e.cyc) begin
                        n_errors++;
                        $display("FAIL strobe dut%0d: got period=%0d stall=%0d cycle=%0d, required period=%0d stall=%0d cycle=%0d",
                                 d, period_w[d], stall_w[d], cyc, e.p, e.s, e.cyc);
                    end
                end
            end
        end
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            l = lvl_q.pop_front();
            case (l.kind)
                0:       act = 32'(period_w[l.d]);
                1:       act = 32'(vld[l.d]);
                default: act = 32'(stall_w[l.d]);
            endcase
            n_checks++;
            if (act != l.v) begin
                n_errors++;
                $display("FAIL level dut%0d kind%0d: got %0d, required %0d at cycle %0d", l.d, l.kind, act, l.v, cyc);
            end
        end
        if (done && !final_done) begin
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (exp_q[d].size() != 0) begin
                    n_errors++;
                    $display("FAIL missing dut%0d: %0d expected strobes never seen, required 0", d, exp_q[d].size());
                end
            end
            final_done = 1'b1;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input int p, input bit s, input longint c);
        exp_t e;
        e.p = p; e.s = s; e.cyc = c;
        exp_q[d].push_back(e);
    endtask

    task automatic push_lvl(input int d, input int kind, input int v);
        lvl_t l;
        l.d = d; l.kind = kind; l.v = v; l.cyc = cyc;
        lvl_q.push_back(l);
    endtask

    // Rises every per cycles; edge 0 expects first_exp (negative: none), later edges expect exp_p.
    task automatic rotate(input int d, input int per, input int n, input int first_exp,
                          input int exp_p, input bit glitch, output longint last_c);
        int hi;
        int lo;
        hi = per / 2;
        lo = per - hi;
        last_c = cyc;
        for (int i = 0; i < n; i++) begin
            int e;
            e = (i == 0) ? first_exp : exp_p;
            last_c = cyc;
            pin[d] = 1'b1;
            if (e >= 0) push_exp(d, e, 1'b0, cyc + 7);
            if (glitch) begin
                wait_cyc(hi / 2);
                pin[d] = 1'b0;
                wait_cyc(3);
                pin[d] = 1'b1;
                wait_cyc(hi - hi / 2 - 3);
            end else begin
                wait_cyc(hi);
            end
            pin[d] = 1'b0;
            if (glitch) begin
                wait_cyc(lo / 2);
                pin[d] = 1'b1;
                wait_cyc(3);
                pin[d] = 1'b0;
                wait_cyc(lo - lo / 2 - 3);
            end else begin
                wait_cyc(lo);
            end
        end
    endtask

    initial begin
        longint lc;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en[d]  = 1'b0;
            pin[d] = 1'b0;
        end
        wait_cyc(3);
        for (int d = 0; d < 3; d++) begin
            push_lvl(d, 0, 0);
            push_lvl(d, 1, 0);
            push_lvl(d, 2, 0);
        end
        wait_cyc(1);
        rst = 1'b0;

        // Reset in the middle of a measurement, then pulses while disabled.
        en[0] = 1'b1;
        wait_cyc(5);
        rotate(0, 100, 2, -1, 100, 1'b0, lc);
        rst   = 1'b1;
        en[0] = 1'b0;
        wait_cyc(1);
        push_lvl(0, 0, 0);
        push_lvl(0, 1, 0);
        push_lvl(0, 2, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pin[0] = 1'b1;
            wait_cyc(20);
            pin[0] = 1'b0;
            wait_cyc(20);
        end

        // Steady rotation at 1000 clocks per revolution.
        en[0] = 1'b1;
        wait_cyc(10);
        rotate(0, 1000, 5, -1, 1000, 1'b0, lc);

        // Enable dropped for 50 cycles mid-period with an edge inside the gap.
        wait_cyc(300);
        en[0] = 1'b0;
        wait_cyc(10);
        pin[0] = 1'b1;
        wait_cyc(20);
        pin[0] = 1'b0;
        wait_cyc(20);
        en[0] = 1'b1;
        wait_cyc(100);
        rotate(0, 1000, 3, -1, 1000, 1'b0, lc);

        // Prescale by 8 with 3-cycle glitches in both phases.
        en[1] = 1'b1;
        wait_cyc(5);
        rotate(1, 1000, 5, -1, 125, 1'b1, lc);

        // 8-bit counter: stall, resume, then edge/saturation collisions.
        en[2] = 1'b1;
        wait_cyc(5);
        rotate(2, 100, 3, -1, 100, 1'b0, lc);
        push_exp(2, 255, 1'b1, lc + 262);
        wait_cyc(400);
        push_lvl(2, 2, 1);
        push_lvl(2, 0, 255);
        push_lvl(2, 1, 0);
        rotate(2, 100, 3, -1, 100, 1'b0, lc);
        push_lvl(2, 2, 0);
        rotate(2, 255, 3, 100, 255, 1'b0, lc);
        rotate(2, 100, 2, 255, 100, 1'b0, lc);
        push_lvl(2, 2, 0);
        push_lvl(2, 0, 100);

        wait_cyc(20);
        done = 1'b1;
        wait_cyc(3);
        if (!final_done) begin
            $display("FAIL final: monitor did not complete end checks, required completion");
            $fatal(1, "monitor stalled");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
